clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures an incoming slow clock or square wave against `clk_in`: reports its period and high time in `clk_in` cycles, plus a no-signal flag. It is the receive-side counterpart of the clock divider. Fed a divider output, it recovers that divider's DIVISOR and high count. Typical uses are self-checking a divided LED/tick clock or measuring an external reference.

## Interface
- WIDTH, 28: width of the counters and of the `period`/`high_time` outputs.
- TIMEOUT, 250000000: cycles without a rising edge before `no_signal` asserts. Must satisfy 2 ≤ TIMEOUT < 2^WIDTH.
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- sig_in  input  1  signal to measure; asynchronous to `clk_in`.
- period  output  WIDTH  last measured rise-to-rise interval, in `clk_in` cycles.
- high_time  output  WIDTH  `clk_in` cycles that `sig_in` was high within that interval.
- meas_valid  output  1  one-cycle pulse when `period`/`high_time` update.
- no_signal  output  1  level; set on timeout, cleared by the next `meas_valid`.

## Operation
- Synchroniser: `sig_in` goes through two flops, s1 then s2, plus a history flop s3.
- Rise detect: `rise = s2 & ~s3`. Rise is the only event used; falling edges are not detected.
- Counters: `cnt` and `hcnt`, each WIDTH bits.
  - Rise cycle: `cnt <= 1`, `hcnt <= 1`.
  - Any other cycle: `cnt <= cnt + 1`, `hcnt <= hcnt + s2`.
- State ARM (after reset or timeout):
  - `cnt` counts; on `rise`, go to MEASURE.
  - No `meas_valid` is produced, because the first edge only arms the meter.
- State MEASURE:
  - On `rise`: `period <= cnt`, `high_time <= hcnt`, `meas_valid <= 1`, `no_signal <= 0`; stay in MEASURE.
  - Otherwise, if `cnt == TIMEOUT`: `no_signal <= 1`, go to ARM; `period`/`high_time` keep their last values.
- Timeout in ARM: `cnt == TIMEOUT` without a rise sets `no_signal <= 1` and restarts `cnt` at 1. This covers a signal stuck from reset.
- Simultaneous rise and `cnt == TIMEOUT` in MEASURE: the rise wins. The measurement is reported with `period = TIMEOUT`, and `no_signal` is not set.
- `cnt` never exceeds TIMEOUT, so there is no wrap-around.
- Minimum measurable period is 2 (`sig_in` toggling every `clk_in` cycle); `high_time` is then 1.
- Pulses shorter than one `clk_in` cycle may be missed; this is accepted behaviour.
- Reset values: `period = 0`, `high_time = 0`, `meas_valid = 0`, `no_signal = 0`, state ARM, `cnt = 0`, `hcnt = 0`, s1/s2/s3 = 0.
- Reset asserted mid-measurement: everything returns to the reset values immediately. The first rise after release only arms the meter.
- `sig_in` high at reset release: s2 going high produces a rise, which arms the meter. This is intended.

## Timing
- `sig_in` rising edge sampled by s1 at edge k:
  - s2 goes high at edge k+1, so `rise` is true during cycle k+1 to k+2.
  - `period`, `high_time` and `meas_valid` register at edge k+2.
  - Total latency from sampling to output: 2 `clk_in` edges.
- `meas_valid` is high for exactly one cycle per measured rise. With a periodic input of period N there is one pulse every N cycles, starting from the second rise after arming.
- `period`/`high_time` are stable between `meas_valid` pulses.
- `no_signal` registers at the edge following the cycle in which `cnt == TIMEOUT`.
- Measurement jitter is ±1 cycle per edge for asynchronous inputs. Inputs generated from `clk_in` measure exactly.

## Test plan
- Divider stimulus, DIVISOR=10, synchronous to `clk_in` → first `meas_valid` on the second rise, then `period = 10`, `high_time = 5` and `meas_valid` every 10 cycles.
- Divider stimulus, DIVISOR=5 → `period = 5`, `high_time = 2`. Also `sig_in` toggling every cycle → `period = 2`, `high_time = 1`.
- TIMEOUT=100: 3 rises spaced 20 cycles, then `sig_in` held low:
  - `meas_valid` twice with `period = 20`.
  - `no_signal = 1` at 100 cycles after the last rise; outputs hold 20.
  - Next two rises spaced 20: first only re-arms, second gives `meas_valid`, `period = 20`, `no_signal = 0`.
- TIMEOUT=100, rises spaced exactly 100 → `meas_valid` with `period = 100`, `no_signal` stays 0. Spacing 101 → `no_signal = 1` and no `meas_valid`.
- Assert `rst` for 1 cycle mid-period, asynchronously between clock edges:
  - All outputs 0 immediately.
  - First rise after release produces no pulse; second rise gives correct `period`.
- Asynchronous `sig_in`, period 37.3 `clk_in` cycles, 1000 periods → every `period` is 37 or 38, and the mean is within 0.1 of 37.3.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow signal in clk_in cycles, with a
// no-signal flag raised when no rising edge arrives within TIMEOUT cycles.
`timescale 1ns/1ps

module clk_period_meter #(
    parameter int unsigned WIDTH   = 28,
    parameter int unsigned TIMEOUT = 250000000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             meas_valid,
    output logic             no_signal
);

    typedef enum logic {
        ST_ARM,
        ST_MEASURE
    } state_e;

    localparam logic [WIDTH-1:0] TIMEOUT_C = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);

    state_e           state_q;
    logic             s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] period_q, high_q;
    logic             valid_q, nosig_q;
    logic             rise;
    logic             at_timeout;

    assign rise       = s2_q & ~s3_q;
    assign at_timeout = (cnt_q == TIMEOUT_C);

    // A timeout restarts the count so cnt never runs past TIMEOUT.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        cnt_d  = cnt_q + ONE_C;
        hcnt_d = hcnt_q + WIDTH'(s2_q);
        if (rise) begin
            cnt_d  = ONE_C;
            hcnt_d = ONE_C;
        end else if (at_timeout) begin
            cnt_d  = ONE_C;
            hcnt_d = WIDTH'(s2_q);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ARM;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            nosig_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            s1_q    <= sig_in;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            valid_q <= 1'b0;

            case (state_q)
                ST_ARM: begin
                    // The first edge only arms; its interval has no defined start.
                    if (rise) begin
                        state_q <= ST_MEASURE;
                    end else if (at_timeout) begin
                        nosig_q <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (rise) begin
                        period_q <= cnt_q;
                        high_q   <= hcnt_q;
                        valid_q  <= 1'b1;
                        nosig_q  <= 1'b0;
                    end else if (at_timeout) begin
                        nosig_q <= 1'b1;
                        state_q <= ST_ARM;
                    end
                end
                default: state_q <= ST_ARM;
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign no_signal  = nosig_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomised and directed bench for clk_period_meter: a timestamp-based model
// of rise events predicts the outputs, checked on every clock cycle.
`timescale 1ns/1ps

module tb_clk_period_meter;

    localparam int W  = 12;
    localparam int TO = 100;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic         sig_in = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         no_signal;

    int tests = 0;
    int fails = 0;

    clk_period_meter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .no_signal (no_signal)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Reference model. Cycle t is the interval after a clock edge; the level the
    // meter acts on in cycle t is sig_in as sampled two edges earlier. A rise at
    // cycle r ends the interval started at the previous rise; the count since the
    // last restart (reset, rise or timeout) reaching TO without a rise is a timeout.
    longint m_t, m_origin, m_last_rise, m_hi_total, m_hi_at_last;
    bit     m_armed;
    bit     m_d1, m_d2, m_d3;
    bit     exp_valid, exp_ns;
    longint exp_period, exp_high;

    task automatic model_reset();
        m_t = 0; m_origin = 0; m_last_rise = 0; m_hi_total = 0; m_hi_at_last = 0;
        m_armed = 0; m_d1 = 0; m_d2 = 0; m_d3 = 0;
        exp_valid = 0; exp_ns = 0; exp_period = 0; exp_high = 0;
    endtask

    task automatic model_step();
        bit lvl, prev_lvl;
        lvl      = m_d2;
        prev_lvl = m_d3;
        exp_valid = 0;
        if (lvl && !prev_lvl) begin
            if (m_armed) begin
                exp_valid  = 1;
                exp_period = m_t - m_last_rise;
                exp_high   = m_hi_total - m_hi_at_last;
                exp_ns     = 0;
            end
            m_armed      = 1;
            m_last_rise  = m_t;
            m_hi_at_last = m_hi_total;
            m_origin     = m_t;
        end else if (m_t - m_origin == TO) begin
            exp_ns   = 1;
            m_armed  = 0;
            m_origin = m_t;
        end
        m_hi_total += longint'(lvl);
        m_d3 = m_d2;
        m_d2 = m_d1;
        m_d1 = sig_in;
        m_t++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk_in);
        if (!rst) begin
            check("meas_valid", longint'(meas_valid), longint'(exp_valid));
            check("no_signal",  longint'(no_signal),  longint'(exp_ns));
            check("period",     longint'(period),     exp_period);
            check("high_time",  longint'(high_time),  exp_high);
        end
    end

    // Monitor: cycle counter, pulse bookkeeping and statistics for the async run.
    longint cyc = 0;
    int     pulse_total = 0;
    longint last_pulse_cyc = 0;
    longint last_gap = 0;
    int     ns_rise_total = 0;
    bit     ns_prev = 0;
    bit     async_on = 0;
    int     a_cnt = 0;
    longint a_sum = 0;
    int     a_bad = 0;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial forever begin
        @(negedge clk_in);
        if (meas_valid === 1'b1) begin
            pulse_total++;
            last_gap       = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
            if (async_on) begin
                a_cnt++;
                a_sum += longint'(period);
                if (period != 37 && period != 38) a_bad++;
            end
        end
        if (no_signal === 1'b1 && !ns_prev) ns_rise_total++;
        ns_prev = (no_signal === 1'b1);
    end

    task automatic do_reset();
        sig_in = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
    endtask

    // Divide-by-div waveform synchronous to clk_in, high for div/2 cycles.
    task automatic divider(input int div, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < div; i++) begin
                sig_in = (i < div / 2);
                @(negedge clk_in);
            end
        end
        sig_in = 1'b0;
    endtask

    // n one-cycle pulses, rising edges spaced by `spacing` cycles.
    task automatic pulses(input int spacing, input int n);
        for (int p = 0; p < n; p++) begin
            sig_in = 1'b1;
            @(negedge clk_in);
            sig_in = 1'b0;
            repeat (spacing - 1) @(negedge clk_in);
        end
    endtask

    initial begin
        int     base;
        int     ns_base;
        bit     found;
        longint ns_cyc;
        real    mean;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        check("rst_period",     longint'(period),     0);
        check("rst_high_time",  longint'(high_time),  0);
        check("rst_meas_valid", longint'(meas_valid), 0);
        check("rst_no_signal",  longint'(no_signal),  0);
        rst = 1'b0;
        @(negedge clk_in);

        // Divide-by-10: six rises, the first only arms
        base = pulse_total;
        divider(10, 6);
        repeat (4) @(negedge clk_in);
        check("div10_pulses", pulse_total - base, 5);
        check("div10_period", longint'(period), 10);
        check("div10_high",   longint'(high_time), 5);
        check("div10_gap",    last_gap, 10);

        // Divide-by-5
        do_reset();
        base = pulse_total;
        divider(5, 6);
        repeat (4) @(negedge clk_in);
        check("div5_pulses", pulse_total - base, 5);
        check("div5_period", longint'(period), 5);
        check("div5_high",   longint'(high_time), 2);

        // Toggle every cycle: minimum period
        do_reset();
        base = pulse_total;
        for (int i = 0; i < 24; i++) begin
            sig_in = ~sig_in;
            @(negedge clk_in);
        end
        sig_in = 1'b0;
        repeat (4) @(negedge clk_in);
        check("tog_pulses", pulse_total - base, 11);
        check("tog_period", longint'(period), 2);
        check("tog_high",   longint'(high_time), 1);
        check("tog_gap",    last_gap, 2);

        // Timeout after three rises, then recovery
        do_reset();
        base = pulse_total;
        pulses(20, 3);
        check("to_pulses", pulse_total - base, 2);
        check("to_period", longint'(period), 20);
        found  = 0;
        ns_cyc = 0;
        for (int i = 0; i < 150 && !found; i++) begin
            @(negedge clk_in);
            if (no_signal === 1'b1) begin
                found  = 1;
                ns_cyc = cyc;
            end
        end
        check("to_ns_seen",  longint'(found), 1);
        check("to_ns_delay", ns_cyc - last_pulse_cyc, 100);
        check("to_hold_period", longint'(period), 20);
        check("to_hold_high",   longint'(high_time), 1);
        base = pulse_total;
        pulses(20, 2);
        check("rearm_pulses", pulse_total - base, 1);
        check("rearm_period", longint'(period), 20);
        check("rearm_ns",     longint'(no_signal), 0);

        // Spacing exactly TIMEOUT: the rise wins
        do_reset();
        base    = pulse_total;
        ns_base = ns_rise_total;
        pulses(100, 3);
        check("sp100_pulses", pulse_total - base, 2);
        check("sp100_period", longint'(period), 100);
        check("sp100_ns_rises", ns_rise_total - ns_base, 0);

        // Spacing TIMEOUT+1: never measures
        do_reset();
        base    = pulse_total;
        ns_base = ns_rise_total;
        pulses(101, 3);
        check("sp101_pulses", pulse_total - base, 0);
        check("sp101_ns", longint'(no_signal), 1);
        check("sp101_ns_rose", longint'(ns_rise_total > ns_base), 1);

        // Asynchronous reset mid-period
        do_reset();
        divider(10, 2);
        repeat (3) @(negedge clk_in);
        check("prerst_period", longint'(period), 10);
        #2 rst = 1'b1;
        #1;
        check("arst_period",     longint'(period),     0);
        check("arst_high_time",  longint'(high_time),  0);
        check("arst_meas_valid", longint'(meas_valid), 0);
        check("arst_no_signal",  longint'(no_signal),  0);
        #9 rst = 1'b0;
        @(negedge clk_in);
        base = pulse_total;
        divider(10, 3);
        repeat (4) @(negedge clk_in);
        check("postrst_pulses", pulse_total - base, 2);
        check("postrst_period", longint'(period), 10);
        check("postrst_high",   longint'(high_time), 5);

        // Asynchronous input, period 37.3 cycles, random start phase
        do_reset();
        repeat ($urandom_range(0, 9)) @(negedge clk_in);
        base     = pulse_total;
        async_on = 1'b1;
        #0.25;
        for (int k = 0; k < 1001; k++) begin
            sig_in = 1'b1;
            #186.5;
            sig_in = 1'b0;
            #186.5;
        end
        async_on = 1'b0;
        repeat (4) @(negedge clk_in);
        check("async_pulses", pulse_total - base, 1000);
        check("async_out_of_range", a_bad, 0);
        mean = (a_cnt > 0) ? real'(a_sum) / real'(a_cnt) : 0.0;
        check_rng("async_mean_x1000", longint'($rtoi(mean * 1000.0 + 0.5)), 37200, 37400);

        repeat (2) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
